// File: rtl/fp32_mul_pkg.sv
// fp32_mul_pkg: shared types and constants for the FP32 multiplier datapath.
package fp32_mul_pkg;

    typedef enum logic [1:0] {
        FP_NORMAL = 2'b00,
        FP_ZERO   = 2'b01,
        FP_INF    = 2'b10,
        FP_NAN    = 2'b11
    } fp_class_e;

    localparam int FLAG_NV = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    localparam int          EXP_MAX = 255;
    localparam logic [31:0] QNAN    = 32'h7FC00000;

endpackage

// File: rtl/fp_round_rne.sv
// fp_round_rne: round-to-nearest-even increment of a normalised mantissa.
module fp_round_rne #(
    parameter int MANT_W = 24
) (
    input  logic [MANT_W-1:0] mant,
    input  logic              g,
    input  logic              s,
    output logic [MANT_W:0]   m25,
    output logic              carry
);

    assign m25   = {1'b0, mant} + (MANT_W+1)'(g & (s | mant[0]));
    assign carry = m25[MANT_W];

endmodule

// File: rtl/fp32_mul_normround.sv
// fp32_mul_normround: two-stage normalise / RNE round / pack of the FP32 multiplier,
// with flush-to-zero of subnormal results and IEEE exception flags.
module fp32_mul_normround
    import fp32_mul_pkg::*;
#(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8,
    parameter int BIAS   = 127
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      valid_i,
    input  logic [2*MANT_W-1:0]       product_i,
    input  logic signed [EXP_W+1:0]   exp_i,
    input  logic                      sign_i,
    input  logic [1:0]                special_i,
    input  logic                      invalid_i,
    output logic                      valid_o,
    output logic [EXP_W+MANT_W-1:0]   result_o,
    output logic [3:0]                flags_o
);

    localparam int PW = 2 * MANT_W;
    localparam int EW = EXP_W + 2;
    localparam int FW = MANT_W - 1;
    localparam int RW = EXP_W + MANT_W;
    localparam logic signed [EW-1:0] E_OVF = EW'(2 * BIAS + 1);

    logic                 hi;
    logic [MANT_W-1:0]    mant_n;
    logic                 g_n;
    logic                 s_n;
    logic signed [EW-1:0] e_n;

    assign hi     = product_i[PW-1];
    assign mant_n = hi ? product_i[PW-1 -: MANT_W] : product_i[PW-2 -: MANT_W];
    assign g_n    = hi ? product_i[MANT_W-1] : product_i[MANT_W-2];
    assign s_n    = hi ? |product_i[MANT_W-2:0] : |product_i[MANT_W-3:0];
    assign e_n    = hi ? exp_i + EW'(1) : exp_i;

    logic                 v1;
    logic                 sign1;
    fp_class_e            cls1;
    logic                 inv1;
    logic signed [EW-1:0] e1;
    logic [MANT_W-1:0]    mant1;
    logic                 g1;
    logic                 s1;

    always_ff @(posedge clk_i) begin
        if (valid_i) begin
            sign1 <= sign_i;
            cls1  <= fp_class_e'(special_i);
            inv1  <= invalid_i;
            e1    <= e_n;
            mant1 <= mant_n;
            g1    <= g_n;
            s1    <= s_n;
        end
    end

    logic [MANT_W:0]      m25;
    logic                 carry;
    logic signed [EW-1:0] e_adj;
    logic [1:0]           unused_m;

    fp_round_rne #(.MANT_W(MANT_W)) u_round (
        .mant  (mant1),
        .g     (g1),
        .s     (s1),
        .m25   (m25),
        .carry (carry)
    );

    assign e_adj    = e1 + EW'(carry);
    assign unused_m = m25[MANT_W -: 2];

    logic [RW-1:0] res_n;
    logic [3:0]    flg_n;

    // Tininess is judged on the pre-rounding exponent, so e1 (not e_adj) gates the flush.
    always_comb begin
        res_n = {sign1, {(RW-1){1'b0}}};
        flg_n = '0;
        if (cls1 == FP_NAN) begin
            res_n          = RW'(QNAN);
            flg_n[FLAG_NV] = inv1;
        end else if (cls1 == FP_INF) begin
            res_n = {sign1, {EXP_W{1'b1}}, {FW{1'b0}}};
        end else if (cls1 == FP_NORMAL && e1 <= 0) begin
            flg_n[FLAG_UF] = 1'b1;
            flg_n[FLAG_NX] = 1'b1;
        end else if (cls1 == FP_NORMAL && e_adj >= E_OVF) begin
            res_n          = {sign1, {EXP_W{1'b1}}, {FW{1'b0}}};
            flg_n[FLAG_OF] = 1'b1;
            flg_n[FLAG_NX] = 1'b1;
        end else if (cls1 == FP_NORMAL) begin
            res_n          = {sign1, e_adj[EXP_W-1:0], m25[FW-1:0]};
            flg_n[FLAG_NX] = g1 | s1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            v1       <= 1'b0;
            valid_o  <= 1'b0;
            result_o <= '0;
            flags_o  <= '0;
        end else begin
            v1      <= valid_i;
            valid_o <= v1;
            if (v1) begin
                result_o <= res_n;
                flags_o  <= flg_n;
            end
        end
    end

endmodule

// File: tb/tb_fp32_mul_normround.sv
// tb_fp32_mul_normround: directed table, streaming/reset sequences and random
// vectors checked against an integer-arithmetic reference model.
module tb_fp32_mul_normround;

    logic        clk = 1'b0;
    logic        rstn_i;
    logic        valid_i;
    logic [47:0] product_i;
    logic signed [9:0] exp_i;
    logic        sign_i;
    logic [1:0]  special_i;
    logic        invalid_i;
    logic        valid_o;
    logic [31:0] result_o;
    logic [3:0]  flags_o;

    always #5 clk = ~clk;

    fp32_mul_normround dut (
        .clk_i     (clk),
        .rstn_i    (rstn_i),
        .valid_i   (valid_i),
        .product_i (product_i),
        .exp_i     (exp_i),
        .sign_i    (sign_i),
        .special_i (special_i),
        .invalid_i (invalid_i),
        .valid_o   (valid_o),
        .result_o  (result_o),
        .flags_o   (flags_o)
    );

    typedef struct {
        logic [47:0] p;
        logic [9:0]  e;
        logic        s;
        logic [1:0]  sp;
        logic        inv;
        logic [31:0] r;
        logic [3:0]  f;
    } vec_t;

    vec_t tbl[16];

    int passed = 0;
    int total  = 0;

    logic        pv[2];
    logic [31:0] pr[2];
    logic [3:0]  pf[2];
    logic [31:0] hr;
    logic [3:0]  hf;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Value-level reference: exact integer quotient/remainder rounding, no G/S bits.
    function automatic logic [35:0] model(input logic [47:0] p, input logic signed [9:0] e,
                                          input logic s, input logic [1:0] sp, input logic inv);
        longint unsigned q, r, half;
        int k, ee;
        if (sp == 2'b11) return {inv, 3'b000, 32'h7FC00000};
        if (sp == 2'b10) return {4'b0000, s, 8'hFF, 23'd0};
        if (sp == 2'b01) return {4'b0000, s, 31'd0};
        k  = p[47] ? 24 : 23;
        ee = int'(e) + int'(p[47]);
        if (ee <= 0) return {4'b0011, s, 31'd0};
        q    = 64'(p) >> k;
        r    = 64'(p) & ((64'd1 << k) - 64'd1);
        half = 64'd1 << (k - 1);
        if (r > half || (r == half && q[0])) q++;
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            ee++;
        end
        if (ee >= 255) return {4'b0101, s, 8'hFF, 23'd0};
        return {3'b000, r != 0, s, 8'(ee), q[22:0]};
    endfunction

    task automatic rnd_vec(output logic [47:0] p, output logic [9:0] e, output logic s,
                           output logic [1:0] sp, output logic inv);
        p = {16'($urandom), $urandom};
        if (p[47:46] == 2'b00) p[46] = 1'b1;
        if ($urandom_range(3) == 0) p[22:0] = {1'($urandom_range(1)), 22'd0};
        case ($urandom_range(7))
            0:       e = 10'(int'($urandom_range(4)) - 2);
            1:       e = 10'(252 + $urandom_range(3));
            default: e = 10'($urandom_range(507) - 126);
        endcase
        s   = 1'($urandom_range(1));
        sp  = ($urandom_range(9) == 0) ? 2'($urandom_range(3)) : 2'b00;
        inv = 1'($urandom_range(1));
    endtask

    task automatic cycle(input logic v, input logic [47:0] p, input logic [9:0] e, input logic s,
                         input logic [1:0] sp, input logic inv, input logic [35:0] expd);
        @(negedge clk);
        chk("valid_o", 32'(valid_o), 32'(pv[1]));
        if (pv[1]) begin
            hr = pr[1];
            hf = pf[1];
        end
        chk("result_o", result_o, hr);
        chk("flags_o", 32'(flags_o), 32'(hf));
        pv[1] = pv[0];
        pr[1] = pr[0];
        pf[1] = pf[0];
        pv[0] = v;
        pr[0] = expd[31:0];
        pf[0] = expd[35:32];
        valid_i   = v;
        product_i = p;
        exp_i     = e;
        sign_i    = s;
        special_i = sp;
        invalid_i = inv;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 2; i++) begin
            pv[i] = 1'b0;
            pr[i] = '0;
            pf[i] = '0;
        end
        hr = '0;
        hf = '0;
    endtask

    initial begin
        logic [47:0] p;
        logic [9:0]  e;
        logic        s, inv;
        logic [1:0]  sp;

        tbl[0]  = '{48'h9000_0000_0000, 10'd127, 1'b0, 2'b00, 1'b0, 32'h40100000, 4'b0000};
        tbl[1]  = '{48'h4000_0040_0000, 10'd127, 1'b0, 2'b00, 1'b0, 32'h3F800000, 4'b0001};
        tbl[2]  = '{48'h4000_00C0_0000, 10'd127, 1'b0, 2'b00, 1'b0, 32'h3F800002, 4'b0001};
        tbl[3]  = '{48'h7FFF_FFFF_FFFF, 10'd127, 1'b0, 2'b00, 1'b0, 32'h40000000, 4'b0001};
        tbl[4]  = '{48'h9000_0000_0000, 10'd254, 1'b0, 2'b00, 1'b0, 32'h7F800000, 4'b0101};
        tbl[5]  = '{48'h4000_0000_0000, 10'd0,   1'b1, 2'b00, 1'b0, 32'h80000000, 4'b0011};
        tbl[6]  = '{48'h4000_0000_0000, 10'd127, 1'b0, 2'b11, 1'b1, 32'h7FC00000, 4'b1000};
        tbl[7]  = '{48'h4000_0000_0000, 10'd127, 1'b1, 2'b10, 1'b0, 32'hFF800000, 4'b0000};
        tbl[8]  = '{48'h4000_0000_0000, 10'd127, 1'b1, 2'b01, 1'b0, 32'h80000000, 4'b0000};
        tbl[9]  = '{48'h4000_0000_0000, 10'd1,   1'b0, 2'b00, 1'b0, 32'h00800000, 4'b0000};
        tbl[10] = '{48'h7FFF_FFFF_FFFF, 10'd254, 1'b0, 2'b00, 1'b0, 32'h7F800000, 4'b0101};
        tbl[11] = '{48'h4000_0000_0000, 10'd127, 1'b1, 2'b11, 1'b0, 32'h7FC00000, 4'b0000};
        tbl[12] = '{48'h4000_0000_0000, 10'h382, 1'b0, 2'b00, 1'b0, 32'h00000000, 4'b0011};
        tbl[13] = '{48'h7FFF_FF00_0000, 10'd254, 1'b0, 2'b00, 1'b0, 32'h7F7FFFFE, 4'b0000};
        tbl[14] = '{48'hFFFF_FF80_0000, 10'd127, 1'b0, 2'b00, 1'b0, 32'h40800000, 4'b0001};
        tbl[15] = '{48'h9000_0000_0000, 10'd127, 1'b1, 2'b00, 1'b0, 32'hC0100000, 4'b0000};

        rstn_i = 1'b0;
        valid_i = 1'b0;
        product_i = '0;
        exp_i = '0;
        sign_i = 1'b0;
        special_i = 2'b00;
        invalid_i = 1'b0;
        clear_model();
        repeat (3) @(negedge clk);
        chk("reset valid_o", 32'(valid_o), 32'd0);
        chk("reset result_o", result_o, 32'd0);
        chk("reset flags_o", 32'(flags_o), 32'd0);
        rstn_i = 1'b1;

        for (int i = 0; i < 16; i++)
            cycle(1'b1, tbl[i].p, tbl[i].e, tbl[i].s, tbl[i].sp, tbl[i].inv, {tbl[i].f, tbl[i].r});
        repeat (2) cycle(1'b0, '0, '0, 1'b0, 2'b00, 1'b0, '0);

        for (int i = 0; i < 8; i++) begin
            rnd_vec(p, e, s, sp, inv);
            cycle(i != 3, p, e, s, sp, inv, model(p, e, s, sp, inv));
        end
        repeat (3) cycle(1'b0, '0, '0, 1'b0, 2'b00, 1'b0, '0);

        for (int i = 0; i < 2; i++) begin
            rnd_vec(p, e, s, sp, inv);
            cycle(1'b1, p, e, s, sp, inv, model(p, e, s, sp, inv));
        end
        @(negedge clk);
        rstn_i  = 1'b0;
        valid_i = 1'b0;
        #1;
        chk("midreset valid_o", 32'(valid_o), 32'd0);
        chk("midreset result_o", result_o, 32'd0);
        chk("midreset flags_o", 32'(flags_o), 32'd0);
        clear_model();
        repeat (2) @(negedge clk);
        rstn_i = 1'b1;
        repeat (4) cycle(1'b0, '0, '0, 1'b0, 2'b00, 1'b0, '0);

        for (int i = 0; i < 400; i++) begin
            rnd_vec(p, e, s, sp, inv);
            cycle($urandom_range(4) != 0, p, e, s, sp, inv, model(p, e, s, sp, inv));
        end
        repeat (3) cycle(1'b0, '0, '0, 1'b0, 2'b00, 1'b0, '0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
